ahb_master_arbiter: RTL and testbench
=====================================

// Module: ahb_master_arbiter
// PURPOSE
//  Shares the core's single AHB-Lite master port between the instruction-fetch and data-memory requesters.
//  Grants one requester at a time and runs one non-pipelined SINGLE transfer (address phase, then data phase).
//  Returns read data, completion and error to the granted side.
//  Sits between the fetch/memory stages and the system AHB-Lite interconnect.
// PARAMETERS
//  ADDR_ALIGN_CHK  default 1  1 = misaligned d_addr for d_size completes as error, with no bus transfer
// PORTS
//  CLK       in   1   clock, all state on rising edge
//  nRST      in   1   reset, asynchronous, active-low
//  i_req     in   1   instruction read request; held until i_ready
//  i_addr    in   32  instruction address (word_t), word aligned
//  i_rdata   out  32  fetched word, valid while i_ready=1
//  i_ready   out  1   one-cycle completion pulse, instruction side
//  i_err     out  1   error qualifier, valid with i_ready
//  d_ren     in   1   data read request; held until d_ready
//  d_wen     in   1   data write request; held until d_ready
//  d_addr    in   32  data address
//  d_wdata   in   32  write data
//  d_size    in   3   HSIZE encoding: 0 = byte, 1 = half, 2 = word
//  d_rdata   out  32  read data, valid while d_ready=1
//  d_ready   out  1   one-cycle completion pulse, data side
//  d_err     out  1   error qualifier, valid with d_ready
//  HADDR     out  32  AHB address          HTRANS  out 2  htrans_t (IDLE/NONSEQ only)
//  HWRITE    out  1   AHB write            HSIZE   out 3  AHB size
//  HWDATA    out  32  AHB write data       HRDATA  in  32 AHB read data
//  HREADY    in   1   AHB ready            HRESP   in  1  AHB response, 1 = ERROR
// BEHAVIOUR
//  Reset (async, nRST=0):
//   - State = ARB_IDLE.
//   - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0.
//   - All *_ready, *_err and *_rdata = 0.
//   - Last grant = GRANT_I.
//   - Reset mid-transfer abandons the transfer with no completion pulse.
//  FSM (all AHB outputs registered):
//   - ARB_IDLE: any request -> select grant, load HADDR/HWRITE/HSIZE, drive HTRANS=NONSEQ, go to ARB_ADDR.
//     Instruction requests use HSIZE=2 and HWRITE=0.
//   - ARB_ADDR: while HREADY=0, hold all address-phase signals. When HREADY=1: HTRANS=IDLE, HWDATA=d_wdata
//     if writing, go to ARB_DATA.
//   - ARB_DATA: HREADY=1 and HRESP=0 -> pulse granted *_ready, capture HRDATA into *_rdata, go to ARB_IDLE.
//     HRESP=1 and HREADY=0 -> go to ARB_ERR.
//   - ARB_ERR: when HREADY=1 -> pulse *_ready with *_err=1, go to ARB_IDLE.
//  Latency:
//   - Request seen at edge T -> NONSEQ at T+1.
//   - Zero-wait slave gives *_ready at T+3.
//   - A new request is accepted the cycle after *_ready (the requester must deassert or present its next request).
//  Grant:
//   - Evaluated only in ARB_IDLE; fixed while busy.
//   - Default: data side has strict priority over instruction.
//  Boundaries:
//   - d_ren and d_wen both 1: treated as a write.
//   - Request dropped mid-transfer: the transfer still completes and the pulse is still issued (requester protocol violation).
//   - Misaligned data access with ADDR_ALIGN_CHK=1: d_ready and d_err pulse one cycle after acceptance; HTRANS stays IDLE.
//   - HRDATA is captured only on completion; *_rdata holds its value until the next completion on that side.
// CONFIGURATION
//  AHB_ARB_RR_EN defined:
//   - Round-robin on simultaneous requests: the side not granted last wins.
//   - Last grant updates on every acceptance.
//  AHB_ARB_RR_EN undefined:
//   - Fixed priority, data over instruction.
//   - Last-grant register is absent.
// STRUCTURE
//  Shared package (common_types_pkg):
//   - typedef enum logic[1:0] arb_state_t {ARB_IDLE, ARB_ADDR, ARB_DATA, ARB_ERR}.
//   - typedef enum logic arb_grant_t {GRANT_I, GRANT_D}.
//   - Reuse word_t and htrans_t.
//  Sub-module:
//   - ahb_grant_sel: combinational grant select from i_req, d_ren|d_wen and the last grant.
//   - Isolates the AHB_ARB_RR_EN variation.
// TESTING
//  1. Zero-wait read: i_req=1, i_addr=0x100, HRDATA=0xDEADBEEF
//     -> NONSEQ at T+1, i_ready at T+3, i_rdata=0xDEADBEEF.
//  2. Write with 2 wait states in the data phase: d_wen=1, d_addr=0x2000_0004, d_wdata=0x1234_5678
//     -> HWDATA stable for 3 cycles, d_ready at T+5.
//  3. Simultaneous i_req and d_ren, repeated 4 transfers:
//     -> fixed priority: D,D,D,D; with AHB_ARB_RR_EN: D,I,D,I.
//  4. ERROR response: HRESP=1/HREADY=0 then HRESP=1/HREADY=1
//     -> d_ready=1 and d_err=1 on the second cycle; the next transfer is normal.
//  5. Misaligned access: d_size=2, d_addr=0x3 -> d_err pulse, no NONSEQ.
//     Then nRST asserted during ARB_DATA -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared types for the AHB-Lite master arbiter: bus word, HTRANS codes,
// arbiter FSM states, grant encoding and the data-side alignment helper.
package common_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA, ARB_ERR} arb_state_t;

    typedef enum logic {GRANT_I, GRANT_D} arb_grant_t;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Only the two low address bits matter for byte/half/word alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
        logic mis;
        case (size)
            3'd1:    mis = addr_lo[0];
            3'd2:    mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ahb_grant_sel.sv
// Combinational grant select between instruction and data requesters.
// AHB_ARB_RR_EN selects round-robin on ties; otherwise data has fixed priority.
module ahb_grant_sel
    import common_types_pkg::*;
(
`ifdef AHB_ARB_RR_EN
    input  logic last_grant,
`endif
    input  logic i_req,
    input  logic d_req,
    output logic grant
);

    always_comb begin
`ifdef AHB_ARB_RR_EN
        if (i_req && d_req) begin
            grant = (arb_grant_t'(last_grant) == GRANT_D) ? GRANT_I : GRANT_D;
        end else begin
            grant = d_req ? GRANT_D : GRANT_I;
        end
`else
        grant = (d_req || !i_req) ? GRANT_D : GRANT_I;
`endif
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-Lite master port between fetch and data requesters, one
// non-pipelined SINGLE transfer at a time. Define AHB_ARB_RR_EN for round-robin grant.
module ahb_master_arbiter
    import common_types_pkg::*;
#(
    parameter int ADDR_ALIGN_CHK = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic        i_err,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic [1:0]  dbg_state
);

    arb_state_t state_q, state_d;
    arb_grant_t grant_q, grant_d;
    htrans_t    htrans_q, htrans_d;
    word_t      haddr_q, haddr_d;
    word_t      hwdata_q, hwdata_d;
    word_t      i_rdata_q, i_rdata_d;
    word_t      d_rdata_q, d_rdata_d;
    logic       hwrite_q, hwrite_d;
    logic [2:0] hsize_q, hsize_d;
    logic       i_ready_q, i_ready_d, i_err_q, i_err_d;
    logic       d_ready_q, d_ready_d, d_err_q, d_err_d;
    logic       sel_grant, d_req, accept, misaligned, done_ok, done_err;
`ifdef AHB_ARB_RR_EN
    arb_grant_t last_q, last_d;
`endif

    assign d_req      = d_ren | d_wen;
    // A completion pulse blocks acceptance for one edge so a still-held request is not replayed.
    assign accept     = (state_q == ARB_IDLE) && !i_ready_q && !d_ready_q && (i_req || d_req);
    assign misaligned = (ADDR_ALIGN_CHK != 0) && is_misaligned(d_addr[1:0], d_size);

    ahb_grant_sel u_grant_sel (
`ifdef AHB_ARB_RR_EN
        .last_grant (last_q),
`endif
        .i_req      (i_req),
        .d_req      (d_req),
        .grant      (sel_grant)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        htrans_d  = htrans_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        hsize_d   = hsize_q;
        hwdata_d  = hwdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        i_err_d   = 1'b0;
        d_ready_d = 1'b0;
        d_err_d   = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
`ifdef AHB_ARB_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    grant_d = arb_grant_t'(sel_grant);
`ifdef AHB_ARB_RR_EN
                    last_d  = arb_grant_t'(sel_grant);
`endif
                    if (arb_grant_t'(sel_grant) == GRANT_I) begin
                        haddr_d  = i_addr;
                        hwrite_d = 1'b0;
                        hsize_d  = HSIZE_WORD;
                        htrans_d = HTRANS_NONSEQ;
                        state_d  = ARB_ADDR;
                    end else if (misaligned) begin
                        d_ready_d = 1'b1;
                        d_err_d   = 1'b1;
                    end else begin
                        haddr_d  = d_addr;
                        hwrite_d = d_wen;
                        hsize_d  = d_size;
                        htrans_d = HTRANS_NONSEQ;
                        state_d  = ARB_ADDR;
                    end
                end
            end
            ARB_ADDR: begin
                if (HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    if (hwrite_q) hwdata_d = d_wdata;
                    state_d  = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (HRESP) begin
                    if (HREADY) done_err = 1'b1;
                    else        state_d  = ARB_ERR;
                end else if (HREADY) begin
                    done_ok = 1'b1;
                end
            end
            ARB_ERR: begin
                if (HREADY) done_err = 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase

        if (done_ok || done_err) begin
            state_d = ARB_IDLE;
            if (grant_q == GRANT_D) begin
                d_ready_d = 1'b1;
                d_err_d   = done_err;
                if (done_ok) d_rdata_d = HRDATA;
            end else begin
                i_ready_d = 1'b1;
                i_err_d   = done_err;
                if (done_ok) i_rdata_d = HRDATA;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ARB_IDLE;
            grant_q   <= GRANT_I;
            htrans_q  <= HTRANS_IDLE;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hsize_q   <= HSIZE_WORD;
            hwdata_q  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            i_err_q   <= 1'b0;
            d_ready_q <= 1'b0;
            d_err_q   <= 1'b0;
`ifdef AHB_ARB_RR_EN
            last_q    <= GRANT_I;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            htrans_q  <= htrans_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            hsize_q   <= hsize_d;
            hwdata_q  <= hwdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            i_err_q   <= i_err_d;
            d_ready_q <= d_ready_d;
            d_err_q   <= d_err_d;
`ifdef AHB_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign i_rdata   = i_rdata_q;
    assign i_ready   = i_ready_q;
    assign i_err     = i_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_err     = d_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter: bench-side AHB slave, scoreboard
// queues for bus address phases and completions, one task per scenario.
module tb_ahb_master_arbiter;
  import common_types_pkg::*;

  localparam int W = 34;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ready, i_err;
  logic        d_ren = 1'b0, d_wen = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [2:0]  d_size = 3'd2;
  logic [31:0] d_rdata;
  logic        d_ready, d_err;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1, HRESP = 1'b0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  word_t i_model, d_model;
  logic [W-1:0] exp_q[$];
  logic [35:0]  bus_q[$];

  // clock / reset
  always #5 CLK = ~CLK;

  ahb_master_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_err(i_err),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .dbg_state(dbg_state)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    repeat (2) step();
    nRST = 1'b1;
    i_model = '0;
    d_model = '0;
    step();
  endtask

  // driver helpers: push expectations when stimulus is defined
  task automatic push_i(input word_t addr, input word_t rdata);
    bus_q.push_back({addr, 1'b0, 3'd2});
    exp_q.push_back({1'b0, 1'b0, rdata});
    i_model = rdata;
  endtask

  task automatic push_d(input word_t addr, input logic wr, input logic [2:0] size,
                        input word_t rdata, input logic err, input logic bus);
    if (bus) bus_q.push_back({addr, wr, size});
    if (err) exp_q.push_back({1'b1, 1'b1, d_model});
    else begin
      exp_q.push_back({1'b1, 1'b0, rdata});
      d_model = rdata;
    end
  endtask

  // Acts as the AHB slave and scoreboard for one transfer started by the caller.
  task automatic run_xfer(input string name, input int waits, input logic err, input word_t rdata,
                          output int nonseq_at, output int ready_at, output int hw_cnt);
    int c, phase, w;
    bit done;
    logic [W-1:0] got, exp;
    logic [35:0] bexp;
    c = 0; phase = 0; w = 0; done = 0;
    nonseq_at = 0; ready_at = 0; hw_cnt = 0;
    HREADY = 1'b1; HRESP = 1'b0;
    while (!done && c < 40) begin
      step();
      c++;
      if (i_ready === 1'b1 || d_ready === 1'b1) begin
        done = 1;
        ready_at = c;
        got = (d_ready === 1'b1) ? {1'b1, d_err, d_rdata} : {1'b0, i_err, i_rdata};
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL %s unexpected completion got=%h", name, got);
        else begin
          exp = exp_q.pop_front();
          if (got !== exp) $display("FAIL %s completion got=%h exp=%h", name, got, exp);
          else n_pass++;
        end
        HREADY = 1'b1; HRESP = 1'b0;
      end else begin
        case (phase)
          0: if (HTRANS === HTRANS_NONSEQ) begin
            nonseq_at = c;
            phase = 1;
            n_checks++;
            if (bus_q.size() == 0) $display("FAIL %s unexpected NONSEQ haddr=%h", name, HADDR);
            else begin
              bexp = bus_q.pop_front();
              if ({HADDR, HWRITE, HSIZE} !== bexp)
                $display("FAIL %s addr_phase got=%h exp=%h", name, {HADDR, HWRITE, HSIZE}, bexp);
              else n_pass++;
            end
          end
          1: begin
            phase = 2;
            w = 0;
            if (HWDATA === d_wdata) hw_cnt++;
            HRDATA = rdata;
            HRESP = err;
            HREADY = (!err && waits == 0);
          end
          default: begin
            w++;
            if (HWDATA === d_wdata) hw_cnt++;
            if (err) HREADY = 1'b1;
            else HREADY = (w >= waits);
          end
        endcase
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s timeout after %0d cycles", name, c);
    end else begin
      step();
      n_checks++;
      if (i_ready !== 1'b0 || d_ready !== 1'b0)
        $display("FAIL %s pulse_width i_ready=%b d_ready=%b exp=0", name, i_ready, d_ready);
      else n_pass++;
    end
  endtask

  task automatic check_reset_values(input string name);
    logic [137:0] got, exp;
    got = {HTRANS, HADDR, HWRITE, HSIZE, HWDATA, i_ready, i_err, i_rdata, d_ready, d_err, d_rdata};
    exp = {2'b00, 32'h0, 1'b0, 3'b010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    n_checks++;
    if (got !== exp) $display("FAIL %s outputs got=%h exp=%h", name, got, exp);
    else n_pass++;
    n_checks++;
    if (dbg_state !== ARB_IDLE) $display("FAIL %s state got=%0d exp=%0d", name, dbg_state, ARB_IDLE);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_values("reset");
  endtask

  task automatic test_zero_wait_read();
    int ns, rd, hw;
    i_req = 1'b1; i_addr = 32'h100;
    push_i(32'h100, 32'hDEAD_BEEF);
    run_xfer("zero_wait_read", 0, 1'b0, 32'hDEAD_BEEF, ns, rd, hw);
    i_req = 1'b0;
    n_checks++;
    if (ns !== 1 || rd !== 3) $display("FAIL zero_wait_read latency nonseq=%0d ready=%0d exp=1/3", ns, rd);
    else n_pass++;
  endtask

  task automatic test_write_wait();
    int ns, rd, hw;
    d_wen = 1'b1; d_addr = 32'h2000_0004; d_wdata = 32'h1234_5678; d_size = 3'd2;
    push_d(32'h2000_0004, 1'b1, 3'd2, 32'h0000_0000, 1'b0, 1'b1);
    run_xfer("write_wait", 2, 1'b0, 32'h0000_0000, ns, rd, hw);
    d_wen = 1'b0;
    n_checks++;
    if (ns !== 1 || rd !== 5) $display("FAIL write_wait latency nonseq=%0d ready=%0d exp=1/5", ns, rd);
    else n_pass++;
    n_checks++;
    if (hw !== 3) $display("FAIL write_wait hwdata_stable got=%0d exp=3", hw);
    else n_pass++;
  endtask

  task automatic test_rw_both();
    int ns, rd, hw;
    d_ren = 1'b1; d_wen = 1'b1; d_addr = 32'h2000_0008; d_wdata = 32'hA5A5_0001; d_size = 3'd2;
    push_d(32'h2000_0008, 1'b1, 3'd2, 32'h0000_55AA, 1'b0, 1'b1);
    run_xfer("rw_both", 0, 1'b0, 32'h0000_55AA, ns, rd, hw);
    d_ren = 1'b0; d_wen = 1'b0;
    n_checks++;
    if (hw !== 1) $display("FAIL rw_both hwdata got=%0d exp=1", hw);
    else n_pass++;
  endtask

  task automatic test_back_to_back_priority();
    int ns, rd, hw;
    bit d_wins;
    word_t rdat;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      i_req = 1'b1; i_addr = 32'h200 + 32'(k * 4);
      d_ren = 1'b1; d_addr = 32'h4000_0000 + 32'(k * 4); d_size = 3'd2;
`ifdef AHB_ARB_RR_EN
      d_wins = (k % 2 == 0);
`else
      d_wins = 1'b1;
`endif
      rdat = 32'hA000_0000 + 32'(k);
      if (d_wins) push_d(d_addr, 1'b0, 3'd2, rdat, 1'b0, 1'b1);
      else push_i(i_addr, rdat);
      run_xfer("priority", 0, 1'b0, rdat, ns, rd, hw);
      n_checks++;
      if (ns !== 1 || rd !== 3) $display("FAIL priority latency k=%0d nonseq=%0d ready=%0d exp=1/3", k, ns, rd);
      else n_pass++;
    end
    i_req = 1'b0; d_ren = 1'b0;
  endtask

  task automatic test_error();
    int ns, rd, hw;
    d_ren = 1'b1; d_addr = 32'h5000_0000; d_size = 3'd2;
    push_d(32'h5000_0000, 1'b0, 3'd2, 32'hBAD0_BAD0, 1'b1, 1'b1);
    run_xfer("error", 0, 1'b1, 32'hBAD0_BAD0, ns, rd, hw);
    n_checks++;
    if (rd !== 4) $display("FAIL error latency ready=%0d exp=4", rd);
    else n_pass++;
    d_addr = 32'h5000_0004;
    push_d(32'h5000_0004, 1'b0, 3'd2, 32'hCAFE_0001, 1'b0, 1'b1);
    run_xfer("after_error", 0, 1'b0, 32'hCAFE_0001, ns, rd, hw);
    d_ren = 1'b0;
    n_checks++;
    if (rd !== 3) $display("FAIL after_error latency ready=%0d exp=3", rd);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    int ns, rd, hw;
    logic [2:0]  sz_tab[5] = '{3'd2, 3'd1, 3'd1, 3'd0, 3'd2};
    logic [31:0] ad_tab[5] = '{32'h3, 32'h1, 32'h2, 32'h3, 32'h4};
    bit          mis_tab[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    word_t rdat;
    for (int k = 0; k < 5; k++) begin
      d_ren = 1'b1; d_size = sz_tab[k]; d_addr = ad_tab[k];
      rdat = 32'h7700_0000 + 32'($urandom_range(0, 16'hFFFF));
      push_d(d_addr, 1'b0, d_size, rdat, mis_tab[k], !mis_tab[k]);
      run_xfer("misaligned", 0, 1'b0, rdat, ns, rd, hw);
      n_checks++;
      if (ns !== (mis_tab[k] ? 0 : 1) || rd !== (mis_tab[k] ? 1 : 3))
        $display("FAIL misaligned k=%0d nonseq=%0d ready=%0d exp=%0d/%0d", k, ns, rd,
                 mis_tab[k] ? 0 : 1, mis_tab[k] ? 1 : 3);
      else n_pass++;
    end
    d_ren = 1'b0;
  endtask

  task automatic test_reset_mid_transfer();
    int pulses;
    d_wen = 1'b1; d_addr = 32'h6000_0000; d_wdata = 32'h0BAD_F00D; d_size = 3'd2;
    HREADY = 1'b1; HRESP = 1'b0;
    step();
    n_checks++;
    if (HTRANS !== HTRANS_NONSEQ) $display("FAIL reset_mid nonseq got=%b exp=10", HTRANS);
    else n_pass++;
    step();
    HREADY = 1'b0;
    step();
    n_checks++;
    if (dbg_state !== ARB_DATA) $display("FAIL reset_mid in_data got=%0d exp=%0d", dbg_state, ARB_DATA);
    else n_pass++;
    nRST = 1'b0;
    #1;
    check_reset_values("reset_mid");
    d_wen = 1'b0;
    HREADY = 1'b1;
    step();
    nRST = 1'b1;
    i_model = '0;
    d_model = '0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (i_ready === 1'b1 || d_ready === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL reset_mid stray_pulses got=%0d exp=0", pulses);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_rw_both();
    test_back_to_back_priority();
    test_error();
    test_misaligned();
    test_reset_mid_transfer();
    n_checks++;
    if (exp_q.size() != 0 || bus_q.size() != 0)
      $display("FAIL leftover_expectations exp_q=%0d bus_q=%0d exp=0", exp_q.size(), bus_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
